datapath_result_monitor: RTL

- Reader end of the datapath result path: captures each executed operation's Data_out and status flags (C,V,D,Z) into a circular history buffer.
- Presents either the newest result (LIVE) or a user-browsed older result (BROWSE) as sign/magnitude fields for the 7-segment drivers.
- Sits between Datapath outputs and the seg7 display logic. Button inputs arrive already debounced as single-cycle pulses.

---
 rtl/mon_pkg.sv | 27 ++
 rtl/sign_mag_conv.sv | 22 ++
 rtl/datapath_result_monitor.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mon_pkg
// Description : Shared definitions for the datapath result monitor: status
//               flag bit positions, monitor state encoding and default sizes.
// Revision    : 1.0 - initial release
// ============================================================================
package mon_pkg;

   // Bit positions inside the {C,V,D,Z} status nibble
   localparam int FLAG_C = 3;
   localparam int FLAG_V = 2;
   localparam int FLAG_D = 1;
   localparam int FLAG_Z = 0;

   // Default history depth and datapath width
   localparam int MON_DEF_DEPTH = 8;
   localparam int MON_DEF_WIDTH = 8;

   // Display mode: newest result or a browsed older one
   typedef enum logic [0:0] {
      MON_LIVE   = 1'b0,
      MON_BROWSE = 1'b1
   } mon_state_t;

endpackage
`default_nettype wire

// File: rtl/sign_mag_conv.sv
`default_nettype none
// ============================================================================
// Module      : sign_mag_conv
// Description : Combinational two's-complement to sign/magnitude converter.
//               The most negative value maps to sign=1 with magnitude
//               2^(WIDTH-1), which is exactly representable in WIDTH bits.
// Revision    : 1.0 - initial release
// ============================================================================
module sign_mag_conv #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] value,
   output logic             sign,
   output logic [WIDTH-1:0] mag
);

   assign sign = value[WIDTH-1];
   // Unary minus wraps -2^(WIDTH-1) back onto itself, giving the right magnitude
   assign mag  = sign ? -value : value;

endmodule
`default_nettype wire

// File: rtl/datapath_result_monitor.sv
`default_nettype none
// ============================================================================
// Module      : datapath_result_monitor
// Description : Captures committed datapath results and flags into a circular
//               history buffer and presents either the newest entry (LIVE)
//               or a user-browsed older entry (BROWSE) in sign/magnitude form.
//               Optional macro MON_OVF_COUNT_EN adds a saturating counter of
//               captures carrying the V flag.
// Revision    : 1.0 - initial release
// ============================================================================
module datapath_result_monitor #(
   parameter int DEPTH = mon_pkg::MON_DEF_DEPTH,
   parameter int WIDTH = mon_pkg::MON_DEF_WIDTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cap_valid,
   input  logic [WIDTH-1:0]         cap_data,
   input  logic [3:0]               cap_flags,
   input  logic                     step,
   input  logic                     live,
   output logic                     disp_valid,
   output logic                     disp_sign,
   output logic [WIDTH-1:0]         disp_mag,
   output logic [3:0]               disp_flags,
   output logic [$clog2(DEPTH)-1:0] disp_age,
   output logic                     browsing,
   output logic [$clog2(DEPTH):0]   count,
   output logic [7:0]               ovf_count
);

   import mon_pkg::*;

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = ADDR_W + 1;

   localparam logic [ADDR_W-1:0] c_ptr_one   = ADDR_W'(1);
   localparam logic [CNT_W-1:0]  c_cnt_one   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  c_depth_cnt = CNT_W'(DEPTH);

   typedef struct packed {
      logic [3:0]       flags;
      logic [WIDTH-1:0] data;
   } entry_t;

   entry_t             r_mem [DEPTH];
   mon_state_t         r_state;
   mon_state_t         w_state_nxt;
   logic [ADDR_W-1:0]  r_age;
   logic [ADDR_W-1:0]  w_age_nxt;
   logic [CNT_W-1:0]   w_age_ext;
   logic [ADDR_W-1:0]  r_wr_ptr;
   logic [CNT_W-1:0]   r_count;
   logic [CNT_W-1:0]   w_count_nxt;
   logic [ADDR_W-1:0]  w_rd_idx;
   entry_t             w_rd_entry;
   logic               w_conv_sign;
   logic [WIDTH-1:0]   w_conv_mag;

   logic               w_disp_valid, r_disp_valid;
   logic               w_disp_sign,  r_disp_sign;
   logic [WIDTH-1:0]   w_disp_mag,   r_disp_mag;
   logic [3:0]         w_disp_flags, r_disp_flags;
   logic [ADDR_W-1:0]  w_disp_age,   r_disp_age;

   // History storage: contents are meaningless until counted, so no reset
   always_ff @(posedge clk) begin
      if (cap_valid) begin
         r_mem[r_wr_ptr] <= '{flags: cap_flags, data: cap_data};
      end
   end

   // State register: mode, browse age, write pointer and fill level
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= MON_LIVE;
         r_age    <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_age   <= w_age_nxt;
         r_count <= w_count_nxt;
         if (cap_valid) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
         end
      end
   end

   // Next-state: a capture shifts the browsed age first, then step applies
   always_comb begin
      w_count_nxt = r_count;
      if (cap_valid && (r_count != c_depth_cnt)) begin
         w_count_nxt = r_count + c_cnt_one;
      end
      w_state_nxt = r_state;
      w_age_nxt   = r_age;
      w_age_ext   = {1'b0, r_age};
      case (r_state)
         MON_LIVE: begin
            w_age_nxt = '0;
            if (step && (w_count_nxt != '0)) begin
               w_state_nxt = MON_BROWSE;
               w_age_nxt   = (w_count_nxt > c_cnt_one) ? c_ptr_one : '0;
            end
         end
         MON_BROWSE: begin
            if (live) begin
               w_state_nxt = MON_LIVE;
               w_age_nxt   = '0;
            end else begin
               if (cap_valid) begin
                  w_age_ext = w_age_ext + c_cnt_one;
               end
               if (w_age_ext == c_depth_cnt) begin
                  // The browsed entry was just overwritten
                  w_state_nxt = MON_LIVE;
                  w_age_nxt   = '0;
               end else begin
                  if (step) begin
                     w_age_ext = w_age_ext + c_cnt_one;
                     if (w_age_ext == w_count_nxt) begin
                        w_age_ext = '0;
                     end
                  end
                  w_age_nxt = w_age_ext[ADDR_W-1:0];
               end
            end
         end
         default: begin
            w_state_nxt = MON_LIVE;
            w_age_nxt   = '0;
         end
      endcase
   end

   // Newest entry sits just below the write pointer; age counts back from it
   assign w_rd_idx   = r_wr_ptr - c_ptr_one - r_age;
   assign w_rd_entry = r_mem[w_rd_idx];

   sign_mag_conv #(
      .WIDTH (WIDTH)
   ) u_sign_mag_conv (
      .value (w_rd_entry.data),
      .sign  (w_conv_sign),
      .mag   (w_conv_mag)
   );

   // Output decode: blank every field while the history is empty
   always_comb begin
      w_disp_valid = 1'b0;
      w_disp_sign  = 1'b0;
      w_disp_mag   = '0;
      w_disp_flags = '0;
      w_disp_age   = '0;
      if (r_count != '0) begin
         w_disp_valid = 1'b1;
         w_disp_sign  = w_conv_sign;
         w_disp_mag   = w_conv_mag;
         w_disp_flags = w_rd_entry.flags;
         w_disp_age   = r_age;
      end
   end

   // Display register stage feeding the 7-segment drivers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_disp_valid <= 1'b0;
         r_disp_sign  <= 1'b0;
         r_disp_mag   <= '0;
         r_disp_flags <= '0;
         r_disp_age   <= '0;
      end else begin
         r_disp_valid <= w_disp_valid;
         r_disp_sign  <= w_disp_sign;
         r_disp_mag   <= w_disp_mag;
         r_disp_flags <= w_disp_flags;
         r_disp_age   <= w_disp_age;
      end
   end

   assign disp_valid = r_disp_valid;
   assign disp_sign  = r_disp_sign;
   assign disp_mag   = r_disp_mag;
   assign disp_flags = r_disp_flags;
   assign disp_age   = r_disp_age;
   assign browsing   = (r_state == MON_BROWSE);
   assign count      = r_count;

`ifdef MON_OVF_COUNT_EN
   logic [7:0] r_ovf_count;

   // Count captures carrying the V flag, holding at 255; cleared only by reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ovf_count <= '0;
      end else if (cap_valid && cap_flags[FLAG_V] && (r_ovf_count != 8'hFF)) begin
         r_ovf_count <= r_ovf_count + 8'd1;
      end
   end

   assign ovf_count = r_ovf_count;
`else
   assign ovf_count = '0;
`endif

endmodule
`default_nettype wire
